// File: rtl/traffic_conflict_monitor.sv
// Lamp safety stage: registers controller lamp outputs and forces all-red on illegal patterns.
// Define TCM_FLASH_EN to flash the reds while in FAULT instead of holding them steady.
module traffic_conflict_monitor #(
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned PERSIST    = 2,
  parameter int unsigned ALLRED     = 8,
  parameter int unsigned FLASH_DIV  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] r_in,
  input  logic [3:0] y_in,
  input  logic [3:0] g_in,
  input  logic       fault_clr,
  output logic [3:0] r_out,
  output logic [3:0] y_out,
  output logic [3:0] g_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam int unsigned AW = $clog2(ALLRED + 1);

  localparam logic [YW-1:0] Y_MAX  = YW'(MIN_YELLOW);
  localparam logic [PW-1:0] P_MAX  = PW'(PERSIST);
  localparam logic [AW-1:0] A_LAST = AW'(ALLRED - 1);

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_DARK     = 3'd1;
  localparam logic [2:0] CODE_MULTI    = 3'd2;
  localparam logic [2:0] CODE_CONFLICT = 3'd3;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd4;
  localparam logic [2:0] CODE_SKIP_Y   = 3'd5;

  if (MIN_YELLOW < 1 || PERSIST < 1 || ALLRED < 1 || FLASH_DIV < 1) begin : g_param_check
    $error("traffic_conflict_monitor: all parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_acnt;
  logic [PW-1:0]       r_pcnt;
  logic [3:0][YW-1:0]  r_ycnt;
  logic [3:0]          r_prev_g;

`ifdef TCM_FLASH_EN
  localparam int unsigned FW     = $clog2(FLASH_DIV + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_DIV - 1);
  logic [FW-1:0]       r_fcnt;
`endif

  logic [3:0]          w_yg;
  logic [3:0]          w_multi_dir;
  logic [3:0]          w_dark_dir;
  logic [3:0]          w_short;
  logic [3:0]          w_skip;
  logic                w_conflict;
  logic                w_static_any;
  logic                w_static_trip;
  logic                w_trip;
  logic [2:0]          w_static_code;
  logic [2:0]          w_event_code;
  logic [2:0]          w_trip_code;
  logic [PW-1:0]       w_pcnt_nxt;
  logic [3:0][YW-1:0]  w_ycnt_nxt;

  // Static and event checks on the current sample, plus next counter values.
  always_comb begin
    w_yg         = y_in | g_in;
    w_conflict   = (w_yg & (w_yg - 4'd1)) != 4'd0;
    w_multi_dir  = (r_in & y_in) | (r_in & g_in) | (y_in & g_in);
    w_dark_dir   = ~(r_in | y_in | g_in);
    w_static_any = w_conflict || (|w_multi_dir) || (|w_dark_dir);

    w_static_code = CODE_NONE;
    if (w_conflict)        w_static_code = CODE_CONFLICT;
    else if (|w_multi_dir) w_static_code = CODE_MULTI;
    else if (|w_dark_dir)  w_static_code = CODE_DARK;

    w_pcnt_nxt = '0;
    if (w_static_any) w_pcnt_nxt = (r_pcnt == P_MAX) ? P_MAX : r_pcnt + PW'(1);
    w_static_trip = w_static_any && (w_pcnt_nxt == P_MAX);

    w_short    = '0;
    w_skip     = '0;
    w_ycnt_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      w_short[i] = !y_in[i] && (r_ycnt[i] != '0) && (r_ycnt[i] < Y_MAX);
      w_skip[i]  = r_prev_g[i] && r_in[i] && !y_in[i] && !g_in[i];
      if (y_in[i]) w_ycnt_nxt[i] = (r_ycnt[i] == Y_MAX) ? Y_MAX : r_ycnt[i] + YW'(1);
    end

    w_event_code = CODE_NONE;
    if (|w_skip)       w_event_code = CODE_SKIP_Y;
    else if (|w_short) w_event_code = CODE_SHORT_Y;

    w_trip      = w_static_trip || (w_event_code != CODE_NONE);
    w_trip_code = w_static_trip ? w_static_code : w_event_code;
  end

  // Monitor state machine with registered lamp drive and fault reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RECOVER;
      r_acnt     <= '0;
      r_pcnt     <= '0;
      r_ycnt     <= '0;
      r_prev_g   <= '0;
      r_out      <= 4'hF;
      y_out      <= 4'h0;
      g_out      <= 4'h0;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
`ifdef TCM_FLASH_EN
      r_fcnt     <= '0;
`endif
    end else begin
      r_pcnt   <= w_pcnt_nxt;
      r_ycnt   <= w_ycnt_nxt;
      r_prev_g <= g_in;

      if (r_state != ST_FAULT && w_trip) begin
        r_state    <= ST_FAULT;
        r_out      <= 4'hF;
        y_out      <= 4'h0;
        g_out      <= 4'h0;
        fault      <= 1'b1;
        fault_code <= w_trip_code;
`ifdef TCM_FLASH_EN
        r_fcnt     <= '0;
`endif
      end else begin
        case (r_state)
          ST_MONITOR: begin
            r_out <= r_in;
            y_out <= y_in;
            g_out <= g_in;
          end
          ST_RECOVER: begin
            if (r_acnt == A_LAST) begin
              r_state <= ST_MONITOR;
              r_out   <= r_in;
              y_out   <= y_in;
              g_out   <= g_in;
            end else begin
              r_acnt <= r_acnt + AW'(1);
              r_out  <= 4'hF;
              y_out  <= 4'h0;
              g_out  <= 4'h0;
            end
          end
          ST_FAULT: begin
            y_out <= 4'h0;
            g_out <= 4'h0;
            if (fault_clr && !w_static_any) begin
              r_state    <= ST_RECOVER;
              r_acnt     <= '0;
              r_out      <= 4'hF;
              fault      <= 1'b0;
              fault_code <= CODE_NONE;
            end else begin
`ifdef TCM_FLASH_EN
              if (r_fcnt == F_LAST) begin
                r_fcnt <= '0;
                r_out  <= ~r_out;
              end else begin
                r_fcnt <= r_fcnt + FW'(1);
              end
`else
              r_out <= 4'hF;
`endif
            end
          end
          default: begin
            r_state <= ST_RECOVER;
            r_acnt  <= '0;
            r_out   <= 4'hF;
            y_out   <= 4'h0;
            g_out   <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule
